assignments_load_arbiter: RTL and testbench

- Sequences and shares the single nonogram clue-ROM reader (assignments_registry) between NREQ requesters, e.g. the solver and the display renderer.
- Per load it:
  - arbitrates round-robin between requesters;
  - clears the registry's sticky done/started state;
  - issues start with the winner's puzzle select;
  - forwards the streamed 20-bit clue words, tagged with their index, to the granted requester;
  - reports completion or error.
- Sits between requester FSMs and the registry; sole driver of the registry's start, address and reset.

---
 rtl/assignments_load_arbiter_if.sv | 20 ++
 rtl/assignments_load_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_assignments_load_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/assignments_load_arbiter_if.sv
// Registry-side bus of assignments_load_arbiter: start/address/reset toward the
// clue-ROM registry and its streamed word/valid/done back.
interface assignments_load_arbiter_if;
  logic        reg_reset_out;
  logic        reg_start_out;
  logic [15:0] reg_address_out;
  logic [19:0] reg_word_in;
  logic        reg_sending_in;
  logic        reg_done_in;

  modport master (
    output reg_reset_out, reg_start_out, reg_address_out,
    input  reg_word_in, reg_sending_in, reg_done_in
  );

  modport slave (
    input  reg_reset_out, reg_start_out, reg_address_out,
    output reg_word_in, reg_sending_in, reg_done_in
  );
endinterface

// File: rtl/assignments_load_arbiter.sv
// assignments_load_arbiter: shares the single clue-ROM registry between NREQ
// requesters. Round-robin grant, registry clear, start with the winner's
// puzzle select, indexed word forwarding, done/error reporting with timeout.
// Optional: define ASSIGN_ARB_CHECKSUM_EN to add checksum_out (XOR of the
// words forwarded in the current load).
module assignments_load_arbiter #(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned WORDS          = 20,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  logic [NREQ-1:0]      req_in,
  input  logic [2*NREQ-1:0]    sel_in,
  output logic [NREQ-1:0]      grant_out,
  output logic [19:0]          word_out,
  output logic [5:0]           word_idx_out,
  output logic                 word_valid_out,
  output logic [NREQ-1:0]      load_done_out,
  output logic [NREQ-1:0]      load_err_out,
  output logic                 busy_out,
`ifdef ASSIGN_ARB_CHECKSUM_EN
  output logic [19:0]          checksum_out,
`endif
  assignments_load_arbiter_if.master reg_if
);

  localparam int unsigned   PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [5:0]    WORDS_C = 6'(WORDS);
  localparam logic [TW-1:0] TLIM    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_START, S_STREAM, S_DONE, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d, win_q, win_d;
  logic [1:0]     sel_q, sel_d;
  logic [5:0]     wcnt_q, wcnt_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           ovf_q, ovf_d;
  logic           rst_hold_q;
  logic [19:0]    word_q, word_d;
  logic [5:0]     idx_q, idx_d;
  logic           vld_q, vld_d;
  logic [19:0]    csum_q, csum_d;

  logic           found;
  logic [PW-1:0]  pick;
  logic [1:0]     sel_pick;
  logic           beat_ok, beat_ovf;
  logic [NREQ-1:0] win_oh;
  logic [1:0]     sel_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_sel
    assign sel_arr[g] = sel_in[2*g+1:2*g];
  end

  // Round-robin pick: first requesting index at or after the pointer, wrapping.
  always_comb begin
    int unsigned j;
    found    = 1'b0;
    pick     = '0;
    sel_pick = '0;
    j        = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr_q) + i) % NREQ;
      if (!found && req_in[PW'(j)]) begin
        found    = 1'b1;
        pick     = PW'(j);
        sel_pick = sel_arr[PW'(j)];
      end
    end
  end

  assign beat_ok  = (state_q == S_STREAM) && reg_if.reg_sending_in && (wcnt_q <  WORDS_C);
  assign beat_ovf = (state_q == S_STREAM) && reg_if.reg_sending_in && (wcnt_q >= WORDS_C);

  // Load sequencing: next state, winner/select latch, word and timeout counters.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = pick;
          sel_d   = sel_pick;
          ptr_d   = PW'((32'(pick) + 1) % NREQ);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        wcnt_d  = '0;
        tcnt_d  = '0;
        ovf_d   = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        if (tcnt_q != TLIM) tcnt_d = tcnt_q + 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (tcnt_q != TLIM) tcnt_d = tcnt_q + 1'b1;
        if (beat_ok)  wcnt_d = wcnt_q + 6'd1;
        if (beat_ovf) ovf_d  = 1'b1;
        // A beat landing in the done cycle is counted before judging the load.
        if (reg_if.reg_done_in)
          state_d = ((wcnt_d == WORDS_C) && !ovf_d) ? S_DONE : S_ERR;
        else if (tcnt_q == TLIM)
          state_d = S_ERR;
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Forwarded-word pipeline stage and running checksum.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    vld_d  = beat_ok;
    csum_d = csum_q;
    if (beat_ok) begin
      word_d = reg_if.reg_word_in;
      idx_d  = wcnt_q;
      csum_d = csum_q ^ reg_if.reg_word_in;
    end
    if (state_q == S_CLEAR) csum_d = '0;
  end

  // State and datapath registers; registry reset is held through async reset.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      sel_q      <= '0;
      wcnt_q     <= '0;
      tcnt_q     <= '0;
      ovf_q      <= 1'b0;
      rst_hold_q <= 1'b1;
      word_q     <= '0;
      idx_q      <= '0;
      vld_q      <= 1'b0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      sel_q      <= sel_d;
      wcnt_q     <= wcnt_d;
      tcnt_q     <= tcnt_d;
      ovf_q      <= ovf_d;
      rst_hold_q <= 1'b0;
      word_q     <= word_d;
      idx_q      <= idx_d;
      vld_q      <= vld_d;
      csum_q     <= csum_d;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    win_oh                 = NREQ'(1) << win_q;
    grant_out              = '0;
    load_done_out          = '0;
    load_err_out           = '0;
    reg_if.reg_start_out   = 1'b0;
    reg_if.reg_address_out = '0;
    reg_if.reg_reset_out   = rst_hold_q;
    busy_out               = (state_q != S_IDLE);
    word_out               = word_q;
    word_idx_out           = idx_q;
    word_valid_out         = vld_q;
    unique case (state_q)
      S_CLEAR: begin
        grant_out            = win_oh;
        reg_if.reg_reset_out = 1'b1;
      end
      S_START: begin
        grant_out              = win_oh;
        reg_if.reg_start_out   = 1'b1;
        reg_if.reg_address_out = {sel_q, 14'b0};
      end
      S_STREAM: begin
        grant_out              = win_oh;
        reg_if.reg_address_out = {sel_q, 14'b0};
      end
      S_DONE: begin
        load_done_out        = win_oh;
        reg_if.reg_reset_out = 1'b1;
      end
      S_ERR: begin
        load_err_out         = win_oh;
        reg_if.reg_reset_out = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ASSIGN_ARB_CHECKSUM_EN
  assign checksum_out = csum_q;
`endif

endmodule

// File: tb/tb_assignments_load_arbiter.sv
// Scoreboard bench for assignments_load_arbiter: stimulus drives requesters and
// a registry model and queues expected words/results; a negedge monitor pops
// and compares whenever the DUT presents a word or a done/err pulse.
module tb_assignments_load_arbiter;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic [1:0]  req_in;
  logic [3:0]  sel_in;
  logic [1:0]  grant_out;
  logic [19:0] word_out;
  logic [5:0]  word_idx_out;
  logic        word_valid_out;
  logic [1:0]  load_done_out;
  logic [1:0]  load_err_out;
  logic        busy_out;
`ifdef ASSIGN_ARB_CHECKSUM_EN
  logic [19:0] checksum_out;
`endif

  assignments_load_arbiter_if rif();

  assignments_load_arbiter #(.NREQ(2), .WORDS(20), .TIMEOUT_CYCLES(64)) dut (
    .clk_in         (clk_in),
    .reset_n_in     (reset_n_in),
    .req_in         (req_in),
    .sel_in         (sel_in),
    .grant_out      (grant_out),
    .word_out       (word_out),
    .word_idx_out   (word_idx_out),
    .word_valid_out (word_valid_out),
    .load_done_out  (load_done_out),
    .load_err_out   (load_err_out),
    .busy_out       (busy_out),
`ifdef ASSIGN_ARB_CHECKSUM_EN
    .checksum_out   (checksum_out),
`endif
    .reg_if         (rif)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [19:0] w; logic [5:0] idx; } wexp_t;
  typedef struct { logic [1:0] d; logic [1:0] e; } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int    checks = 0;
  int    errors = 0;
  int    start_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Monitor: pop and compare on every forwarded word and every result pulse.
  always @(negedge clk_in) begin
    if (rif.reg_start_out) start_cnt++;
    if (word_valid_out) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got %0h idx %0d expected none", word_out, word_idx_out);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        if (word_out !== e.w || word_idx_out !== e.idx) begin
          errors++;
          $display("FAIL word: got %0h idx %0d expected %0h idx %0d", word_out, word_idx_out, e.w, e.idx);
        end
      end
    end
    if (load_done_out != 2'b00 || load_err_out != 2'b00) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got done=%b err=%b expected none", load_done_out, load_err_out);
      end else begin
        rexp_t r;
        r = rq.pop_front();
        if (load_done_out !== r.d || load_err_out !== r.e) begin
          errors++;
          $display("FAIL result: got done=%b err=%b expected done=%b err=%b", load_done_out, load_err_out, r.d, r.e);
        end
      end
    end
  end

  // One complete load from IDLE; n words of value base+k, done after the stream.
  task automatic do_load(input logic [1:0] g, input logic [15:0] addr, input int n,
                         input logic [19:0] base, input int drop_at, input logic [1:0] req_after);
    logic [19:0] cs;
    int          sc0;
    bit          ok;
    rexp_t       r;
    wexp_t       w;
    ok  = (n == 20);
    cs  = '0;
    sc0 = start_cnt;
    tick();
    chk("clear_grant", 32'(grant_out), 32'(g));
    chk("clear_regrst", 32'(rif.reg_reset_out), 32'd1);
    chk("clear_busy", 32'(busy_out), 32'd1);
    chk("clear_nostart", 32'(rif.reg_start_out), 32'd0);
    tick();
    chk("start_pulse", 32'(rif.reg_start_out), 32'd1);
    chk("start_addr", 32'(rif.reg_address_out), 32'(addr));
    chk("start_regrst", 32'(rif.reg_reset_out), 32'd0);
    chk("start_grant", 32'(grant_out), 32'(g));
    tick();
    chk("stream_addr", 32'(rif.reg_address_out), 32'(addr));
    chk("stream_nostart", 32'(rif.reg_start_out), 32'd0);
    for (int k = 0; k < n; k++) begin
      rif.reg_sending_in = 1'b1;
      rif.reg_word_in    = base + 20'(k);
      if (k < 20) begin
        w.w   = base + 20'(k);
        w.idx = 6'(k);
        wq.push_back(w);
        cs = cs ^ (base + 20'(k));
      end
      if (k == drop_at) req_in = 2'b00;
      tick();
    end
    rif.reg_sending_in = 1'b0;
    rif.reg_done_in    = 1'b1;
    r.d = ok ? g : 2'b00;
    r.e = ok ? 2'b00 : g;
    rq.push_back(r);
    tick();
    chk("end_grant_clear", 32'(grant_out), 32'd0);
    chk("end_regrst", 32'(rif.reg_reset_out), 32'd1);
`ifdef ASSIGN_ARB_CHECKSUM_EN
    chk("checksum", 32'(checksum_out), 32'(cs));
`endif
    req_in = req_after;
    rif.reg_done_in = 1'b0;
    tick();
    chk("idle_busy", 32'(busy_out), 32'd0);
    chk("start_count", 32'(start_cnt - sc0), 32'd1);
  endtask

  initial begin
    int    n;
    rexp_t r;
    wexp_t w;
    reset_n_in = 1'b0;
    req_in = '0;
    sel_in = '0;
    rif.reg_word_in = '0;
    rif.reg_sending_in = 1'b0;
    rif.reg_done_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_grant", 32'(grant_out), 32'd0);
    chk("rst_valid", 32'(word_valid_out), 32'd0);
    chk("rst_word", 32'(word_out), 32'd0);
    chk("rst_idx", 32'(word_idx_out), 32'd0);
    chk("rst_done", 32'(load_done_out), 32'd0);
    chk("rst_err", 32'(load_err_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_regrst", 32'(rif.reg_reset_out), 32'd1);
    chk("rst_start", 32'(rif.reg_start_out), 32'd0);
    chk("rst_addr", 32'(rif.reg_address_out), 32'd0);
`ifdef ASSIGN_ARB_CHECKSUM_EN
    chk("rst_checksum", 32'(checksum_out), 32'd0);
`endif
    reset_n_in = 1'b1;
    chk("release_regrst_held", 32'(rif.reg_reset_out), 32'd1);
    tick();
    chk("release_regrst_drop", 32'(rif.reg_reset_out), 32'd0);

    // Contention: both requesting for three loads -> 01, 10, 01.
    req_in = 2'b11;
    sel_in = 4'b0110;  // requester1 sel=01, requester0 sel=10
    do_load(2'b01, 16'h8000, 20, 20'h00100, -1, 2'b11);
    do_load(2'b10, 16'h4000, 20, 20'h00200, -1, 2'b11);
    do_load(2'b01, 16'h8000, 20, 20'h00300, -1, 2'b00);

    // Single load, words 1..20.
    req_in = 2'b01;
    sel_in = 4'b0010;
    do_load(2'b01, 16'h8000, 20, 20'h00001, -1, 2'b00);
`ifdef ASSIGN_ARB_CHECKSUM_EN
    chk("checksum_1_to_20_held", 32'(checksum_out), 32'h14);
`endif

    // Timeout: registry never reports done.
    req_in = 2'b01;
    sel_in = 4'b0010;
    r.d = 2'b00;
    r.e = 2'b01;
    rq.push_back(r);
    tick();
    chk("to_grant", 32'(grant_out), 32'd1);
    req_in = 2'b00;
    tick();
    chk("to_start", 32'(rif.reg_start_out), 32'd1);
    n = 0;
    while (n < 200 && load_err_out == 2'b00) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd64);
    chk("to_err", 32'(load_err_out), 32'd1);
    chk("to_regrst", 32'(rif.reg_reset_out), 32'd1);
    chk("to_grant_clear", 32'(grant_out), 32'd0);
    tick();
    chk("to_idle", 32'(busy_out), 32'd0);

    // Short stream (19) and long stream (21): both errors.
    req_in = 2'b01;
    do_load(2'b01, 16'h8000, 19, 20'h00400, -1, 2'b00);
    req_in = 2'b01;
    do_load(2'b01, 16'h8000, 21, 20'h00500, -1, 2'b00);

    // Async reset in the middle of the stream, after word index 7.
    req_in = 2'b01;
    sel_in = 4'b0010;
    tick();
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      rif.reg_sending_in = 1'b1;
      rif.reg_word_in    = 20'h00600 + 20'(k);
      w.w   = 20'h00600 + 20'(k);
      w.idx = 6'(k);
      wq.push_back(w);
      tick();
    end
    rif.reg_sending_in = 1'b0;
    @(negedge clk_in);
    #1;
    reset_n_in = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant_out), 32'd0);
    chk("mid_rst_valid", 32'(word_valid_out), 32'd0);
    chk("mid_rst_busy", 32'(busy_out), 32'd0);
    chk("mid_rst_regrst", 32'(rif.reg_reset_out), 32'd1);
    chk("mid_rst_addr", 32'(rif.reg_address_out), 32'd0);
    chk("mid_rst_word", 32'(word_out), 32'd0);
    chk("mid_rst_result", 32'({load_done_out, load_err_out}), 32'd0);
`ifdef ASSIGN_ARB_CHECKSUM_EN
    chk("mid_rst_checksum", 32'(checksum_out), 32'd0);
`endif
    req_in = 2'b00;
    repeat (2) @(posedge clk_in);
    #3;
    reset_n_in = 1'b1;
    chk("mid_release_regrst_held", 32'(rif.reg_reset_out), 32'd1);
    tick();
    chk("mid_release_regrst_drop", 32'(rif.reg_reset_out), 32'd0);
    chk("mid_release_idle", 32'(busy_out), 32'd0);
    req_in = 2'b10;
    sel_in = 4'b0100;  // requester1 sel=01
    do_load(2'b10, 16'h4000, 20, 20'h00700, -1, 2'b00);

    // Request withdrawn at word 5: load still completes for requester 0.
    req_in = 2'b01;
    sel_in = 4'b0010;
    do_load(2'b01, 16'h8000, 20, 20'h00800, 5, 2'b00);

    @(negedge clk_in);
    #1;
    chk("words_drained", 32'(wq.size()), 32'd0);
    chk("results_drained", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected finish before 200000");
    $fatal(1);
  end

endmodule
